// File: rtl/difftest_step_issuer_pkg.sv
// Shared types and helpers for the difftest step issuer.
//   state_e : issuer FSM states (RUN accumulates/batches, DRAIN empties, HALT is terminal)
//   sat_min : issue amount, the accumulator clipped to what one step pulse can carry
package difftest_step_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  function automatic int unsigned sat_min(input int unsigned acc, input int unsigned lim);
    return (acc < lim) ? acc : lim;
  endfunction

endpackage

// File: rtl/difftest_step_issuer_if.sv
// Bundle between the commit-count aggregator / stepping bridge and the step issuer.
//   in_valid/in_count/in_ready : per-cycle commit counts (ready = accumulator has room)
//   flush_req/flush_done       : drain request and completion pulse
//   simv_result                : deferred software result, non-zero = stop
//   step/pending/halted        : step pulse, accumulator value, halted flag
// master = aggregator/bridge side, slave = issuer.
interface difftest_step_issuer_if #(
  parameter int STEP_WIDTH  = 8,
  parameter int EVENT_WIDTH = 4
);
  logic                   in_valid;
  logic [EVENT_WIDTH-1:0] in_count;
  logic                   in_ready;
  logic                   flush_req;
  logic                   flush_done;
  logic [7:0]             simv_result;
  logic [STEP_WIDTH-1:0]  step;
  logic [STEP_WIDTH:0]    pending;
  logic                   halted;

  modport master (
    output in_valid, in_count, flush_req, simv_result,
    input  in_ready, flush_done, step, pending, halted
  );

  modport slave (
    input  in_valid, in_count, flush_req, simv_result,
    output in_ready, flush_done, step, pending, halted
  );
endinterface

// File: rtl/difftest_step_idle_timer.sv
// Saturating idle counter for the step issuer.
//   clock, reset : clock, synchronous active-high reset
//   clr          : zero the counter (has priority over en)
//   en           : count one idle cycle
//   hit          : counter sits at LIMIT
module difftest_step_idle_timer #(
  parameter int LIMIT = 16,
  parameter int W     = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)                            cnt <= '0;
    else if (clr)                         cnt <= '0;
    else if (en && (cnt != W'(LIMIT)))    cnt <= cnt + 1'b1;
  end

  assign hit = (cnt == W'(LIMIT));
endmodule

// File: rtl/difftest_step_issuer.sv
// Batches per-cycle commit counts into one-cycle step pulses for the difftest
// stepping bridge, and stops for good once the software reports a non-zero result.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : commit input handshake, flush request/done, simv_result in,
//                  step pulse / pending accumulator / halted out
module difftest_step_issuer
  import difftest_step_pkg::*;
#(
  parameter int STEP_WIDTH    = 8,
  parameter int EVENT_WIDTH   = 4,
  parameter int BATCH_MAX     = 64,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  difftest_step_issuer_if.slave  bus
);
  localparam int unsigned STEP_MAX = (1 << STEP_WIDTH) - 1;
  localparam int unsigned IN_MAX   = (1 << EVENT_WIDTH) - 1;
  localparam int unsigned ACC_MAX  = 2 * STEP_MAX + 1;
  localparam int          AW       = STEP_WIDTH + 1;
  localparam int          TW       = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  state_e                state, state_nxt;
  logic [AW-1:0]         acc, acc_nxt;
  logic [7:0]            res_q;
  logic [STEP_WIDTH-1:0] issued, step_q;
  logic                  issue, fire, rdy, tmr_hit, done_nxt, done_q, halted_q;

  // Headroom check guarantees acc + in_count can never wrap.
  assign rdy  = (state == RUN) && (acc <= AW'(ACC_MAX - IN_MAX));
  assign fire = bus.in_valid && rdy;

  always_comb begin
    issue     = 1'b0;
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      RUN: begin
        if (res_q != 8'd0) begin
          state_nxt = HALT;                 // halt suppresses any issue this cycle
        end else if (bus.flush_req) begin
          issue     = (acc != '0);
          state_nxt = DRAIN;
        end else if ((acc >= AW'(BATCH_MAX)) ||
                     ((FLUSH_TIMEOUT != 0) && tmr_hit && (acc != '0))) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (res_q != 8'd0) state_nxt = HALT;
        else               issue     = (acc != '0);
      end
      default: ;                            // HALT: frozen until reset
    endcase

    issued  = issue ? STEP_WIDTH'(sat_min(32'(acc), STEP_MAX)) : '0;
    acc_nxt = acc - AW'(issued) + (fire ? AW'(bus.in_count) : '0);

    // A drain that empties the accumulator (including an empty flush, or one
    // finished in the request cycle) completes here and returns to RUN.
    if ((state_nxt == DRAIN) && (acc_nxt == '0)) begin
      state_nxt = RUN;
      done_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      acc      <= '0;
      res_q    <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      res_q    <= bus.simv_result;          // DPI side writes asynchronously
      step_q   <= issued;
      done_q   <= done_nxt;
      halted_q <= (state_nxt == HALT);
    end
  end

  difftest_step_idle_timer #(.LIMIT(FLUSH_TIMEOUT), .W(TW)) u_idle (
    .clock (clock),
    .reset (reset),
    .clr   ((fire && (bus.in_count != '0)) || issue),
    .en    (acc != '0),
    .hit   (tmr_hit)
  );

  assign bus.in_ready   = rdy;
  assign bus.step       = step_q;
  assign bus.pending    = acc;
  assign bus.flush_done = done_q;
  assign bus.halted     = halted_q;
endmodule
